// File: rtl/mips_pc_sequencer.sv
// MIPS-style program counter sequencer: sequential fetch, branch/jump/jump-register
// redirects with an optional branch delay slot, synchronous exceptions and a halt trap.
module mips_pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int          DELAY_SLOT   = 1,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CntEn,
    input  logic [1:0]  PCControl,
    input  logic [31:0] read_data_1,
    input  logic [31:0] signed_offset,
    input  logic [25:0] target,
    input  logic        exc_req,
    output logic [31:0] pc,
    output logic [31:0] epc,
    output logic        in_delay_slot,
    output logic        addr_err,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_SEQ   = 2'b00,
        ST_DSLOT = 2'b01,
        ST_HALT  = 2'b10
    } state_t;

    localparam logic [1:0] CTL_BRANCH = 2'b00;
    localparam logic [1:0] CTL_JUMP   = 2'b01;
    localparam logic [1:0] CTL_JR     = 2'b10;
    localparam logic [1:0] CTL_SEQ    = 2'b11;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] tgt_q, tgt_d;
    logic        ids_q, ids_d;
    logic        addr_err_q, addr_err_d;
    logic        halted_q, halted_d;

    logic [31:0] pc_plus4;
    logic [31:0] redir_tgt;
    logic        jr_misaligned;
    logic        take_exc;
    logic        unused_offset_hi;

    function automatic logic [31:0] branch_target(input logic [31:0] pc_i,
                                                   input logic [15:0] off_i);
        logic [31:0] sext;
        sext = {{14{off_i[15]}}, off_i, 2'b00};
        return pc_i + 32'd4 + sext;
    endfunction

    function automatic logic [31:0] jump_target(input logic [31:0] pc_i,
                                                 input logic [25:0] idx_i);
        logic [31:0] p4;
        p4 = pc_i + 32'd4;
        return {p4[31:28], idx_i, 2'b00};
    endfunction

    assign unused_offset_hi = ^signed_offset[31:16];

    always_comb begin
        pc_plus4      = pc_q + 32'd4;
        redir_tgt     = read_data_1;
        jr_misaligned = (PCControl == CTL_JR) && (read_data_1[1:0] != 2'b00);
        case (PCControl)
            CTL_BRANCH: redir_tgt = branch_target(pc_q, signed_offset[15:0]);
            CTL_JUMP:   redir_tgt = jump_target(pc_q, target);
            default:    redir_tgt = read_data_1;
        endcase
    end

    // A misaligned jump-register target only raises an exception on an enabled advance in SEQ;
    // in DSLOT PCControl is ignored, so nothing there can fault.
    always_comb begin
        take_exc = 1'b0;
        if (state_q != ST_HALT) begin
            take_exc = exc_req ||
                       ((state_q == ST_SEQ) && CntEn && jr_misaligned);
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        epc_d      = epc_q;
        tgt_d      = tgt_q;
        ids_d      = ids_q;
        halted_d   = halted_q;
        addr_err_d = 1'b0;

        if (take_exc) begin
            pc_d       = EXC_VECTOR;
            epc_d      = (state_q == ST_DSLOT) ? (pc_q - 32'd4) : pc_q;
            tgt_d      = 32'h0;
            ids_d      = 1'b0;
            state_d    = ST_SEQ;
            addr_err_d = (state_q == ST_SEQ) && CntEn && jr_misaligned;
        end else if (CntEn) begin
            case (state_q)
                ST_SEQ: begin
                    if (PCControl == CTL_SEQ) begin
                        pc_d = pc_plus4;
                    end else if (DELAY_SLOT != 0) begin
                        tgt_d   = redir_tgt;
                        pc_d    = pc_plus4;
                        ids_d   = 1'b1;
                        state_d = ST_DSLOT;
                    end else if (redir_tgt == HALT_ADDR) begin
                        pc_d     = HALT_ADDR;
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end else begin
                        pc_d = redir_tgt;
                    end
                end
                ST_DSLOT: begin
                    // The halt trap fires when the delayed redirect actually lands.
                    pc_d  = tgt_q;
                    tgt_d = 32'h0;
                    ids_d = 1'b0;
                    if (tgt_q == HALT_ADDR) begin
                        halted_d = 1'b1;
                        state_d  = ST_HALT;
                    end else begin
                        state_d = ST_SEQ;
                    end
                end
                default: begin
                    state_d = ST_HALT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_SEQ;
            pc_q       <= RESET_VECTOR;
            epc_q      <= 32'h0;
            tgt_q      <= 32'h0;
            ids_q      <= 1'b0;
            addr_err_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            tgt_q      <= tgt_d;
            ids_q      <= ids_d;
            addr_err_q <= addr_err_d;
            halted_q   <= halted_d;
        end
    end

    assign pc            = pc_q;
    assign epc           = epc_q;
    assign in_delay_slot = ids_q;
    assign addr_err      = addr_err_q;
    assign halted        = halted_q;

endmodule

// File: tb/tb_mips_pc_sequencer.sv
// Directed-vector bench for mips_pc_sequencer with a queue-based scoreboard; a second
// instance runs without a delay slot.
module tb_mips_pc_sequencer;

    localparam logic [1:0] BR = 2'b00;
    localparam logic [1:0] JP = 2'b01;
    localparam logic [1:0] JR = 2'b10;
    localparam logic [1:0] SQ = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        CntEn = 1'b0;
    logic [1:0]  PCControl = SQ;
    logic [31:0] read_data_1 = 32'h0;
    logic [31:0] signed_offset = 32'h0;
    logic [25:0] target = 26'h0;
    logic        exc_req = 1'b0;

    logic [31:0] pc_a, epc_a, pc_b, epc_b;
    logic        ids_a, ae_a, h_a, ids_b, ae_b, h_b;

    typedef struct {
        string       name;
        bit          sel;
        logic [31:0] pc;
        logic [31:0] epc;
        logic        ids;
        logic        ae;
        logic        h;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mips_pc_sequencer u_ds (
        .clk(clk), .rst(rst), .CntEn(CntEn), .PCControl(PCControl),
        .read_data_1(read_data_1), .signed_offset(signed_offset), .target(target),
        .exc_req(exc_req), .pc(pc_a), .epc(epc_a), .in_delay_slot(ids_a),
        .addr_err(ae_a), .halted(h_a)
    );

    mips_pc_sequencer #(.DELAY_SLOT(0)) u_nd (
        .clk(clk), .rst(rst), .CntEn(CntEn), .PCControl(PCControl),
        .read_data_1(read_data_1), .signed_offset(signed_offset), .target(target),
        .exc_req(exc_req), .pc(pc_b), .epc(epc_b), .in_delay_slot(ids_b),
        .addr_err(ae_b), .halted(h_b)
    );

    task automatic chk32(input string nm, input string fld, input logic [31:0] act,
                         input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s got %08h expected %08h", nm, fld, act, exp);
        end
    endtask

    // Monitor: the DUT presents a new state on every clock edge; check it just after.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_vec++;
            if (e.sel == 1'b0) begin
                chk32(e.name, "pc", pc_a, e.pc);
                chk32(e.name, "epc", epc_a, e.epc);
                chk32(e.name, "ids", {31'b0, ids_a}, {31'b0, e.ids});
                chk32(e.name, "addr_err", {31'b0, ae_a}, {31'b0, e.ae});
                chk32(e.name, "halted", {31'b0, h_a}, {31'b0, e.h});
            end else begin
                chk32(e.name, "pc", pc_b, e.pc);
                chk32(e.name, "epc", epc_b, e.epc);
                chk32(e.name, "ids", {31'b0, ids_b}, {31'b0, e.ids});
                chk32(e.name, "addr_err", {31'b0, ae_b}, {31'b0, e.ae});
                chk32(e.name, "halted", {31'b0, h_b}, {31'b0, e.h});
            end
        end
    end

    task automatic vec(input string nm, input bit r, input bit cen, input logic [1:0] ctl,
                       input logic [31:0] rd1, input logic [31:0] off, input logic [25:0] tg,
                       input bit ex, input bit sel, input logic [31:0] pc_e,
                       input logic [31:0] epc_e, input bit ids_e, input bit ae_e, input bit h_e);
        exp_t e;
        @(negedge clk);
        rst           = r;
        CntEn         = cen;
        PCControl     = ctl;
        read_data_1   = rd1;
        signed_offset = off;
        target        = tg;
        exc_req       = ex;
        e.name = nm; e.sel = sel; e.pc = pc_e; e.epc = epc_e;
        e.ids = ids_e; e.ae = ae_e; e.h = h_e;
        sb.push_back(e);
    endtask

    initial begin
        int guard;
        //   name        rst cen ctl  rd1           off           tgt      exc sel pc            epc           ids ae h
        vec("reset",     1, 0, SQ, 32'h0,        32'h0,        26'h0,   0, 0, 32'hBFC00000, 32'h0,        0, 0, 0);
        vec("seq1",      0, 1, SQ, 32'h0,        32'h0,        26'h0,   0, 0, 32'hBFC00004, 32'h0,        0, 0, 0);
        vec("seq2",      0, 1, SQ, 32'h0,        32'h0,        26'h0,   0, 0, 32'hBFC00008, 32'h0,        0, 0, 0);
        vec("seq3",      0, 1, SQ, 32'h0,        32'h0,        26'h0,   0, 0, 32'hBFC0000C, 32'h0,        0, 0, 0);
        vec("hold",      0, 0, BR, 32'h0,        32'h0000FFFE, 26'h0,   0, 0, 32'hBFC0000C, 32'h0,        0, 0, 0);
        vec("seq4",      0, 1, SQ, 32'h0,        32'h0,        26'h0,   0, 0, 32'hBFC00010, 32'h0,        0, 0, 0);
        vec("br_back",   0, 1, BR, 32'h0,        32'h1234FFFE, 26'h0,   0, 0, 32'hBFC00014, 32'h0,        1, 0, 0);
        vec("ds_hold",   0, 0, SQ, 32'h0,        32'h0,        26'h0,   0, 0, 32'hBFC00014, 32'h0,        1, 0, 0);
        vec("ds_br_ign", 0, 1, BR, 32'h0,        32'h00000100, 26'h0,   0, 0, 32'hBFC0000C, 32'h0,        0, 0, 0);
        for (int i = 1; i <= 5; i++)
            vec("seq_run", 0, 1, SQ, 32'h0, 32'h0, 26'h0, 0, 0, 32'hBFC0000C + 32'(4 * i), 32'h0, 0, 0, 0);
        vec("jump",      0, 1, JP, 32'h0,        32'h0,        26'h0000040, 0, 0, 32'hBFC00024, 32'h0,  1, 0, 0);
        vec("jump_ds",   0, 1, SQ, 32'h0,        32'h0,        26'h0,   0, 0, 32'hB0000100, 32'h0,        0, 0, 0);
        vec("jr",        0, 1, JR, 32'hBFC00040, 32'h0,        26'h0,   0, 0, 32'hB0000104, 32'h0,        1, 0, 0);
        vec("jr_ds",     0, 1, SQ, 32'h0,        32'h0,        26'h0,   0, 0, 32'hBFC00040, 32'h0,        0, 0, 0);
        vec("jr_misal",  0, 1, JR, 32'h80000002, 32'h0,        26'h0,   0, 0, 32'hBFC00380, 32'hBFC00040, 0, 1, 0);
        vec("ae_clear",  0, 1, SQ, 32'h0,        32'h0,        26'h0,   0, 0, 32'hBFC00384, 32'hBFC00040, 0, 0, 0);
        vec("jr2",       0, 1, JR, 32'hBFC00050, 32'h0,        26'h0,   0, 0, 32'hBFC00388, 32'hBFC00040, 1, 0, 0);
        vec("jr2_ds",    0, 1, SQ, 32'h0,        32'h0,        26'h0,   0, 0, 32'hBFC00050, 32'hBFC00040, 0, 0, 0);
        vec("br_fwd",    0, 1, BR, 32'h0,        32'h00000010, 26'h0,   0, 0, 32'hBFC00054, 32'hBFC00040, 1, 0, 0);
        vec("exc_ds",    0, 0, SQ, 32'h0,        32'h0,        26'h0,   1, 0, 32'hBFC00380, 32'hBFC00050, 0, 0, 0);
        vec("exc_prio",  0, 1, JP, 32'h0,        32'h0,        26'h0,   1, 0, 32'hBFC00380, 32'hBFC00380, 0, 0, 0);
        vec("jr_top",    0, 1, JR, 32'hFFFFFFF8, 32'h0,        26'h0,   0, 0, 32'hBFC00384, 32'hBFC00380, 1, 0, 0);
        vec("top_ds",    0, 1, SQ, 32'h0,        32'h0,        26'h0,   0, 0, 32'hFFFFFFF8, 32'hBFC00380, 0, 0, 0);
        vec("seq_fffc",  0, 1, SQ, 32'h0,        32'h0,        26'h0,   0, 0, 32'hFFFFFFFC, 32'hBFC00380, 0, 0, 0);
        vec("wrap",      0, 1, SQ, 32'h0,        32'h0,        26'h0,   0, 0, 32'h00000000, 32'hBFC00380, 0, 0, 0);
        vec("seq_4",     0, 1, SQ, 32'h0,        32'h0,        26'h0,   0, 0, 32'h00000004, 32'hBFC00380, 0, 0, 0);
        vec("jr_halt",   0, 1, JR, 32'h0,        32'h0,        26'h0,   0, 0, 32'h00000008, 32'hBFC00380, 1, 0, 0);
        vec("halt",      0, 1, SQ, 32'h0,        32'h0,        26'h0,   0, 0, 32'h00000000, 32'hBFC00380, 0, 0, 1);
        vec("halt_seq",  0, 1, SQ, 32'h0,        32'h0,        26'h0,   0, 0, 32'h00000000, 32'hBFC00380, 0, 0, 1);
        vec("halt_exc",  0, 1, SQ, 32'h0,        32'h0,        26'h0,   1, 0, 32'h00000000, 32'hBFC00380, 0, 0, 1);
        vec("halt_br",   0, 1, BR, 32'h0,        32'h00000010, 26'h0,   0, 0, 32'h00000000, 32'hBFC00380, 0, 0, 1);
        vec("reset2",    1, 0, SQ, 32'h0,        32'h0,        26'h0,   0, 0, 32'hBFC00000, 32'h0,        0, 0, 0);
        vec("br_pend",   0, 1, BR, 32'h0,        32'h00000010, 26'h0,   0, 0, 32'hBFC00004, 32'h0,        1, 0, 0);
        vec("rst_ds",    1, 1, SQ, 32'h0,        32'h0,        26'h0,   0, 0, 32'hBFC00000, 32'h0,        0, 0, 0);
        vec("post_rst",  0, 1, SQ, 32'h0,        32'h0,        26'h0,   0, 0, 32'hBFC00004, 32'h0,        0, 0, 0);
        vec("jr_mis_off",0, 0, JR, 32'h00000003, 32'h0,        26'h0,   0, 0, 32'hBFC00004, 32'h0,        0, 0, 0);
        vec("nd_reset",  1, 0, SQ, 32'h0,        32'h0,        26'h0,   0, 1, 32'hBFC00000, 32'h0,        0, 0, 0);
        vec("nd_br",     0, 1, BR, 32'h0,        32'h00000001, 26'h0,   0, 1, 32'hBFC00008, 32'h0,        0, 0, 0);
        vec("nd_halt",   0, 1, JR, 32'h0,        32'h0,        26'h0,   0, 1, 32'h00000000, 32'h0,        0, 0, 1);
        vec("nd_held",   0, 1, SQ, 32'h0,        32'h0,        26'h0,   1, 1, 32'h00000000, 32'h0,        0, 0, 1);

        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (sb.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d vectors left unchecked, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
